tlul_socket_m1_arb: RTL and testbench

- M:1 TL-UL host arbiter: shares one downstream TL-UL port (typically the host port of the 1:N socket) between M upstream hosts.
- Round-robin grant with request lock.
- Records the granted host index per accepted request in an in-order ID FIFO, and routes each response to the host at the FIFO head.
- Relies on in-order responses downstream, which the 1:N socket guarantees by stalling device switches until outstanding responses drain.

---
 rtl/tlul_socket_m1_arb_pkg.sv | 38 +++
 rtl/tlul_socket_m1_arb_if.sv | 12 +
 rtl/tlul_socket_m1_arb_rr_arbiter.sv | 50 +++++
 rtl/tlul_socket_m1_arb.sv | 127 ++++++++++++
 tb/tb_tlul_socket_m1_arb.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/tlul_socket_m1_arb_pkg.sv
// TL-UL 32-bit channel types plus small helpers shared by the M:1 host arbiter.
package tluh_32_pkg;
  localparam int unsigned TL_AW  = 32;
  localparam int unsigned TL_DW  = 32;
  localparam int unsigned TL_AIW = 8;
  localparam int unsigned TL_DIW = 1;

  typedef struct packed {
    logic                a_valid;
    logic [2:0]          a_opcode;
    logic [2:0]          a_param;
    logic [1:0]          a_size;
    logic [TL_AIW-1:0]   a_source;
    logic [TL_AW-1:0]    a_address;
    logic [TL_DW/8-1:0]  a_mask;
    logic [TL_DW-1:0]    a_data;
    logic                d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic                d_valid;
    logic [2:0]          d_opcode;
    logic [2:0]          d_param;
    logic [1:0]          d_size;
    logic [TL_AIW-1:0]   d_source;
    logic [TL_DIW-1:0]   d_sink;
    logic [TL_DW-1:0]    d_data;
    logic                d_error;
    logic                a_ready;
  } tl_d2h_t;
endpackage

package tlul_socket_m1_arb_pkg;
  // Wraps an index already known to be below 2*n back into 0..n-1 without a divider.
  function automatic int unsigned rr_wrap(input int unsigned idx, input int unsigned n);
    return (idx >= n) ? (idx - n) : idx;
  endfunction
endpackage

// File: rtl/tlul_socket_m1_arb_if.sv
// Bundles the M upstream host ports and the shared downstream port of the arbiter.
interface tlul_socket_m1_arb_if #(
  parameter int unsigned M = 3
);
  tluh_32_pkg::tl_h2d_t tl_h_i [M];
  tluh_32_pkg::tl_d2h_t tl_h_o [M];
  tluh_32_pkg::tl_h2d_t tl_d_o;
  tluh_32_pkg::tl_d2h_t tl_d_i;

  modport slave  (input tl_h_i, output tl_h_o, output tl_d_o, input tl_d_i);
  modport master (output tl_h_i, input tl_h_o, input tl_d_o, output tl_d_i);
endinterface

// File: rtl/tlul_socket_m1_arb_rr_arbiter.sv
// Round-robin index arbiter with an external lock that pins the grant to a held beat.
module tlul_rr_arbiter
  import tlul_socket_m1_arb_pkg::*;
#(
  parameter  int unsigned N  = 3,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [N-1:0]  req_i,
  input  logic          lock_i,
  input  logic [IW-1:0] lock_idx_i,
  input  logic          advance_i,
  output logic [IW-1:0] gnt_idx_o,
  output logic          any_req_o
);
  logic [IW-1:0] rr_ptr_q;
  logic [IW-1:0] rr_ptr_d;
  logic [IW-1:0] scan_idx_s;
  logic [IW-1:0] cand_s;
  logic          found_s;
  logic          hit_s;

  assign any_req_o = |req_i;
  assign gnt_idx_o = lock_i ? lock_idx_i : scan_idx_s;
  assign rr_ptr_d  = IW'(rr_wrap(32'(gnt_idx_o) + 32'd1, N));

  // Scan rr_ptr, rr_ptr+1, ... and keep the first requester found.
  always_comb begin
    scan_idx_s = '0;
    found_s    = 1'b0;
    cand_s     = '0;
    hit_s      = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      cand_s     = IW'(rr_wrap(32'(rr_ptr_q) + i, N));
      hit_s      = ~found_s & req_i[cand_s];
      scan_idx_s = hit_s ? cand_s : scan_idx_s;
      found_s    = found_s | hit_s;
    end
  end

  // Pointer moves just past the winner on every accepted beat.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
    end else if (advance_i) begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
endmodule

// File: rtl/tlul_socket_m1_arb.sv
// M:1 TL-UL host arbiter: round-robin with beat lock, responses routed via an in-order ID FIFO.
module tlul_socket_m1_arb
  import tluh_32_pkg::*;
  import tlul_socket_m1_arb_pkg::*;
#(
  parameter  int unsigned M      = 3,
  parameter  int unsigned MaxOut = 4,
  localparam int unsigned HW     = $clog2(M),
  localparam int unsigned CW     = $clog2(MaxOut + 1),
  localparam int unsigned PW     = $clog2(MaxOut)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  tlul_socket_m1_arb_if.slave  bus,
  output logic [CW-1:0]        outstanding_o,
  output logic                 rsp_err_o
);
  logic [M-1:0]  req_s;
  logic [HW-1:0] gnt_s;
  logic [HW-1:0] head_s;
  logic [HW-1:0] grant_q;
  logic          lock_q;
  logic          lock_d;
  logic          any_req_s;
  logic          full_s;
  logic          a_valid_s;
  logic          a_ready_s;
  logic          accept_s;
  logic          has_head_s;
  logic          d_ready_s;
  logic          pop_s;
  logic [HW-1:0] id_fifo_q [MaxOut];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          rsp_err_q;

  tlul_rr_arbiter #(.N(M)) u_rr (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_i      (req_s),
    .lock_i     (lock_q),
    .lock_idx_i (grant_q),
    .advance_i  (accept_s),
    .gnt_idx_o  (gnt_s),
    .any_req_o  (any_req_s)
  );

  // Reset is folded into the handshake so the ports go quiet the instant rst_ni falls.
  assign full_s     = (count_q == CW'(MaxOut));
  assign a_valid_s  = any_req_s & ~full_s & rst_ni;
  assign a_ready_s  = bus.tl_d_i.a_ready & ~full_s & rst_ni;
  assign accept_s   = a_valid_s & bus.tl_d_i.a_ready;
  assign has_head_s = (count_q != '0);
  assign head_s     = id_fifo_q[rd_ptr_q];
  assign d_ready_s  = has_head_s ? bus.tl_h_i[head_s].d_ready : 1'b1;
  assign pop_s      = has_head_s & bus.tl_d_i.d_valid & d_ready_s;
  assign lock_d     = a_valid_s & ~accept_s;

  assign outstanding_o = count_q;
  assign rsp_err_o     = rsp_err_q;

  // Collect request valids for the arbiter.
  always_comb begin
    req_s = '0;
    for (int unsigned g = 0; g < M; g++) begin
      req_s[g] = bus.tl_h_i[g].a_valid;
    end
  end

  // Downstream A channel follows the granted host; D ready follows the FIFO head.
  always_comb begin
    bus.tl_d_o         = bus.tl_h_i[gnt_s];
    bus.tl_d_o.a_valid = a_valid_s;
    bus.tl_d_o.d_ready = d_ready_s;
  end

  // D fields broadcast to every host; only the head owner sees d_valid.
  always_comb begin
    for (int unsigned g = 0; g < M; g++) begin
      bus.tl_h_o[g]         = bus.tl_d_i;
      bus.tl_h_o[g].d_valid = bus.tl_d_i.d_valid & has_head_s & (head_s == HW'(g));
      bus.tl_h_o[g].a_ready = a_ready_s & (gnt_s == HW'(g));
    end
  end

  // Occupancy next-state; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    case ({accept_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Lock, ID FIFO, occupancy and the sticky orphan-response flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q    <= 1'b0;
      grant_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rsp_err_q <= 1'b0;
      for (int unsigned k = 0; k < MaxOut; k++) begin
        id_fifo_q[k] <= '0;
      end
    end else begin
      lock_q  <= lock_d;
      count_q <= count_d;
      if (lock_d) begin
        grant_q <= gnt_s;
      end
      if (accept_s) begin
        id_fifo_q[wr_ptr_q] <= gnt_s;
        wr_ptr_q            <= wr_ptr_q + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      if (bus.tl_d_i.d_valid & ~has_head_s) begin
        rsp_err_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_tlul_socket_m1_arb.sv
// Random multi-host traffic against a queue-based model of the M:1 arbiter and an in-order device.
module tb_tlul_socket_m1_arb;
  import tluh_32_pkg::*;

  localparam int unsigned M      = 3;
  localparam int unsigned MaxOut = 4;
  localparam int unsigned CW     = $clog2(MaxOut + 1);

  logic          clk    = 1'b0;
  logic          rst_ni = 1'b0;
  logic [CW-1:0] outstanding;
  logic          rsp_err;

  tlul_socket_m1_arb_if #(.M(M)) bus ();

  tlul_socket_m1_arb #(.M(M), .MaxOut(MaxOut)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .bus           (bus),
    .outstanding_o (outstanding),
    .rsp_err_o     (rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct { int host; logic [31:0] data; } exp_t;
  typedef struct { logic [31:0] data; int rdy; } rsp_t;

  exp_t        exp_q[$];
  rsp_t        rsp_q[$];
  bit          hv    [M];
  bit          hdr   [M];
  bit          acc   [M];
  logic [31:0] haddr [M];
  int          checks = 0;
  int          errors = 0;
  int          rr_start, locked_host, cyc, cnt_snap, seq, max_out, mon_h;
  int          lat_lo, lat_hi, ar_pct;
  bit          dev_ar, hosts_on, spur, mon_en;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] resp_of(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  function automatic tl_h2d_t host_beat(input int h);
    tl_h2d_t b;
    b           = '0;
    b.a_valid   = hv[h];
    b.a_opcode  = 3'd4;
    b.a_size    = 2'd2;
    b.a_source  = 8'(h);
    b.a_address = haddr[h];
    b.a_mask    = 4'hF;
    b.a_data    = ~haddr[h];
    b.d_ready   = hdr[h];
    return b;
  endfunction

  // Drive phase (just after posedge): check occupancy, then update hosts and device.
  task automatic drive_cycle();
    cnt_snap = exp_q.size();
    chk("outstanding", 64'(outstanding), 64'(cnt_snap));
    if (int'(outstanding) > max_out) max_out = int'(outstanding);
    for (int h = 0; h < M; h++) begin
      if (acc[h]) begin
        hv[h]  = 1'b0;
        acc[h] = 1'b0;
      end
      if (!hv[h] && hosts_on && ($urandom_range(99) < 40)) begin
        hv[h]    = 1'b1;
        haddr[h] = {4'(h), 12'(seq), 16'($urandom)};
        seq++;
      end
      hdr[h] = ($urandom_range(99) < 75);
      bus.tl_h_i[h] = host_beat(h);
    end
    dev_ar = ($urandom_range(99) < ar_pct);
    bus.tl_d_i = '0;
    bus.tl_d_i.a_ready = dev_ar;
    if (spur) begin
      bus.tl_d_i.d_valid = 1'b1;
      bus.tl_d_i.d_data  = 32'hDEAD_BEEF;
    end else if (rsp_q.size() > 0 && rsp_q[0].rdy <= cyc) begin
      bus.tl_d_i.d_valid  = 1'b1;
      bus.tl_d_i.d_opcode = 3'd1;
      bus.tl_d_i.d_data   = rsp_q[0].data;
    end
  endtask

  // Observe phase (negedge): predict the winner from the round-robin rules and push expectations.
  task automatic observe_cycle();
    bit anyv;
    bit full;
    bit exp_av;
    int win;
    anyv = 1'b0;
    for (int h = 0; h < M; h++) anyv |= hv[h];
    full   = (cnt_snap >= MaxOut);
    exp_av = anyv && !full;
    win    = -1;
    chk("a_valid", 64'(bus.tl_d_o.a_valid), 64'(exp_av));
    if (exp_av) begin
      if (locked_host >= 0) win = locked_host;
      else for (int k = 0; k < M; k++)
        if (win < 0 && hv[(rr_start + k) % M]) win = (rr_start + k) % M;
      chk("a_address", 64'(bus.tl_d_o.a_address), 64'(haddr[win]));
    end
    if (exp_av || full)
      for (int h = 0; h < M; h++)
        chk("a_ready", 64'(bus.tl_h_o[h].a_ready), 64'((h == win) && dev_ar));
    if (exp_av && dev_ar) begin
      exp_q.push_back('{win, resp_of(haddr[win])});
      rsp_q.push_back('{resp_of(bus.tl_d_o.a_address), cyc + int'($urandom_range(lat_hi, lat_lo))});
      acc[win]    = 1'b1;
      rr_start    = (win + 1) % M;
      locked_host = -1;
    end else if (exp_av) begin
      locked_host = win;
    end
    if (bus.tl_d_i.d_valid && bus.tl_d_o.d_ready && rsp_q.size() > 0) void'(rsp_q.pop_front());
    cyc++;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      drive_cycle();
      @(negedge clk);
      observe_cycle();
    end
  endtask

  // Response monitor: each downstream beat must reach the oldest expected host.
  always @(negedge clk) begin
    if (mon_en && rst_ni) begin
      if (bus.tl_d_i.d_valid) begin
        if (exp_q.size() == 0) begin
          chk("drop_d_ready", 64'(bus.tl_d_o.d_ready), 64'd1);
          for (int g = 0; g < M; g++) chk("drop_d_valid", 64'(bus.tl_h_o[g].d_valid), 64'd0);
        end else begin
          mon_h = exp_q[0].host;
          for (int g = 0; g < M; g++) chk("route_d_valid", 64'(bus.tl_h_o[g].d_valid), 64'(g == mon_h));
          chk("route_d_ready", 64'(bus.tl_d_o.d_ready), 64'(hdr[mon_h]));
          if (hdr[mon_h]) begin
            chk("rsp_data", 64'(bus.tl_h_o[mon_h].d_data), 64'(exp_q[0].data));
            void'(exp_q.pop_front());
          end
        end
      end else begin
        for (int g = 0; g < M; g++) chk("idle_d_valid", 64'(bus.tl_h_o[g].d_valid), 64'd0);
      end
    end
  end

  initial begin
    rr_start = 0; locked_host = -1; cyc = 0; seq = 0; max_out = 0; mon_h = 0;
    hosts_on = 1'b0; spur = 1'b0; mon_en = 1'b0; dev_ar = 1'b0;
    lat_lo = 1; lat_hi = 4; ar_pct = 70;
    for (int h = 0; h < M; h++) begin
      hv[h] = 1'b0; hdr[h] = 1'b1; acc[h] = 1'b0; haddr[h] = 32'h0;
      bus.tl_h_i[h] = host_beat(h);
    end
    bus.tl_d_i = '0;

    #12;
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    chk("rst_a_valid", 64'(bus.tl_d_o.a_valid), 64'd0);
    for (int h = 0; h < M; h++) begin
      chk("rst_a_ready", 64'(bus.tl_h_o[h].a_ready), 64'd0);
      chk("rst_d_valid", 64'(bus.tl_h_o[h].d_valid), 64'd0);
    end
    @(negedge clk);
    rst_ni   = 1'b1;
    mon_en   = 1'b1;
    hosts_on = 1'b1;

    run_cycles(600);
    lat_lo = 15; lat_hi = 25; ar_pct = 100;
    run_cycles(300);
    lat_lo = 1; lat_hi = 3; ar_pct = 50;
    run_cycles(400);

    hosts_on = 1'b0; ar_pct = 100; lat_lo = 1; lat_hi = 2;
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0 && !hv[0] && !hv[1] && !hv[2]) break;
      run_cycles(1);
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    chk("peak_outstanding", 64'(max_out), 64'(MaxOut));
    chk("rsp_err_clean", 64'(rsp_err), 64'd0);

    spur = 1'b1;
    run_cycles(1);
    spur = 1'b0;
    run_cycles(3);
    chk("rsp_err_sticky", 64'(rsp_err), 64'd1);

    hosts_on = 1'b1; lat_lo = 50; lat_hi = 60; ar_pct = 100;
    run_cycles(8);
    chk("pre_reset_outstanding", 64'(outstanding != '0), 64'd1);
    @(posedge clk);
    #3;
    rst_ni = 1'b0;
    #1;
    chk("async_outstanding", 64'(outstanding), 64'd0);
    chk("async_rsp_err", 64'(rsp_err), 64'd0);
    chk("async_a_valid", 64'(bus.tl_d_o.a_valid), 64'd0);
    for (int h = 0; h < M; h++) begin
      chk("async_a_ready", 64'(bus.tl_h_o[h].a_ready), 64'd0);
      chk("async_d_valid", 64'(bus.tl_h_o[h].d_valid), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
